// File: rtl/overlay_fetch.sv
// rtl/overlay_fetch.sv - overlay bitmap prefetcher: SDRAM ch1 words to one ABGR4444 pixel per strobe
module overlay_fetch #(
  parameter int DEPTH = 4,
  parameter int AW    = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          ce_pix,
  input  logic          hblank,
  input  logic          vblank,
  input  logic          vsync,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_data,
  output logic [3:0]    bg_r,
  output logic [3:0]    bg_g,
  output logic [3:0]    bg_b,
  output logic [3:0]    bg_a,
  output logic          underrun
);
  localparam int          PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] { IDLE, PRIME, RUN } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic          half_q, half_d;
  logic          out_q, out_d;
  logic          drop_q, drop_d;
  logic          req_q, req_d;
  logic          underrun_q, underrun_d;
  logic [15:0]   pix_q, pix_d;
  logic          vsync_q;

  logic          frame_start, active, ack_v, issue, push, consume, pop;
  logic [31:0]   head;

  assign frame_start = vsync & ~vsync_q;
  assign active      = (state_q != IDLE);
  assign ack_v       = mem_ack & out_q;
  assign head        = fifo_q[rd_ptr_q];
  // A request never issues on a restart cycle so the flush cannot race a fresh fetch.
  assign issue       = enable & active & ~frame_start & ~out_q & (count_q != FULL);
  assign push        = enable & active & ~frame_start & ack_v & ~drop_q;
  assign consume     = enable & (state_q == RUN) & ~frame_start & ce_pix & ~hblank & ~vblank;
  assign pop         = consume & (count_q != '0) & half_q;

  assign mem_req  = req_q;
  assign mem_addr = req_addr_q;
  assign {bg_a, bg_b, bg_g, bg_r} = pix_q;
  assign underrun = underrun_q;

  // Next state: FSM, single-outstanding request tracking, FIFO pointers and pixel output.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    addr_d     = addr_q;
    req_addr_d = req_addr_q;
    half_d     = half_q;
    out_d      = out_q;
    drop_d     = drop_q;
    req_d      = 1'b0;
    underrun_d = underrun_q;
    pix_d      = pix_q;

    if (ack_v) begin
      out_d  = 1'b0;
      drop_d = 1'b0;
    end
    if (issue) begin
      out_d      = 1'b1;
      req_d      = 1'b1;
      req_addr_d = addr_q;
    end

    if (!enable) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      half_d   = 1'b0;
      pix_d    = '0;
      if (out_q && !ack_v) drop_d = 1'b1;
    end else if (frame_start) begin
      state_d    = PRIME;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      addr_d     = '0;
      half_d     = 1'b0;
      underrun_d = 1'b0;
      if (out_q && !ack_v) drop_d = 1'b1;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        addr_d   = addr_q + AW'(2);
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      if (consume) begin
        if (count_q != '0) begin
          pix_d  = half_q ? head[31:16] : head[15:0];
          half_d = ~half_q;
        end else begin
          pix_d      = '0;
          underrun_d = 1'b1;
        end
      end
      if (state_q == PRIME && count_q == FULL) state_d = RUN;
    end
  end

  // FIFO storage needs no reset: count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= mem_data;
  end

  // State and control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      req_addr_q <= '0;
      half_q     <= 1'b0;
      out_q      <= 1'b0;
      drop_q     <= 1'b0;
      req_q      <= 1'b0;
      underrun_q <= 1'b0;
      pix_q      <= '0;
      vsync_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      req_addr_q <= req_addr_d;
      half_q     <= half_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      req_q      <= req_d;
      underrun_q <= underrun_d;
      pix_q      <= pix_d;
      vsync_q    <= vsync;
    end
  end

endmodule

// File: tb/tb_overlay_fetch.sv
// tb/tb_overlay_fetch.sv - self-checking bench for overlay_fetch
module tb_overlay_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, ce_pix, hblank, vblank, vsync;
  logic        mem_req, mem_ack;
  logic [23:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  bg_r, bg_g, bg_b, bg_a;
  logic        underrun;

  logic        w_enable, w_req, w_ack, w_underrun;
  logic [2:0]  w_addr;
  logic [31:0] w_data;
  logic [3:0]  w_r, w_g, w_b, w_a;

  overlay_fetch dut (
    .clk(clk), .reset(reset), .enable(enable), .ce_pix(ce_pix),
    .hblank(hblank), .vblank(vblank), .vsync(vsync),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b), .bg_a(bg_a), .underrun(underrun)
  );

  overlay_fetch #(.DEPTH(2), .AW(3)) dut_w (
    .clk(clk), .reset(reset), .enable(w_enable), .ce_pix(ce_pix),
    .hblank(hblank), .vblank(vblank), .vsync(vsync),
    .mem_req(w_req), .mem_addr(w_addr), .mem_ack(w_ack), .mem_data(w_data),
    .bg_r(w_r), .bg_g(w_g), .bg_b(w_b), .bg_a(w_a), .underrun(w_underrun)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_lat = 5;
  int last_ack_cyc = 0;
  int pix_idx = 0;
  logic [23:0] req_log[$];
  int          req_cyc[$];
  logic [2:0]  w_log[$];
  logic [15:0] expq[$];
  logic [15:0] last_exp = 16'h0;

  typedef struct packed { logic ce; logic hb; logic vb; logic adv; } vec_t;
  vec_t vecs [16];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    if (a == 24'h0) return 32'h8421_F0C3;
    return {a[15:0] ^ 16'h5A5A, a[15:0] + 16'h1111};
  endfunction

  function automatic logic [15:0] model_pix(input int i);
    logic [31:0] w;
    w = mem_word(24'((i / 2) * 2));
    return (i % 2 == 1) ? w[31:16] : w[15:0];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ce, input logic hb, input logic vb, input logic adv, input string nm);
    ce_pix = ce; hblank = hb; vblank = vb;
    if (adv) begin
      last_exp = model_pix(pix_idx);
      pix_idx++;
    end
    expq.push_back(last_exp);
    tick();
    check(nm, {16'h0, bg_a, bg_b, bg_g, bg_r}, {16'h0, expq.pop_front()});
    ce_pix = 1'b0; hblank = 1'b0; vblank = 1'b0;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    pix_idx = 0;
  endtask

  task automatic wait_reqs(input int n, input int bound, input string nm);
    int k = 0;
    while (req_log.size() < n && k < bound) begin
      tick();
      k++;
    end
    check(nm, 32'(req_log.size() >= n), 32'd1);
  endtask

  // SDRAM channel 1 model for the main instance
  initial begin
    logic [23:0] a;
    mem_ack = 1'b0;
    mem_data = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        a = mem_addr;
        req_log.push_back(a);
        req_cyc.push_back(cyc);
        repeat (ack_lat) @(posedge clk);
        #1;
        mem_ack = 1'b1;
        mem_data = mem_word(a);
        check("addr_stable", {8'h0, mem_addr}, {8'h0, a});
        last_ack_cyc = cyc;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
      end
    end
  end

  // Memory model for the narrow-address instance
  initial begin
    logic [2:0] a;
    w_ack = 1'b0;
    w_data = 32'h0;
    forever begin
      @(negedge clk);
      if (w_req === 1'b1) begin
        a = w_addr;
        w_log.push_back(a);
        repeat (2) @(posedge clk);
        #1;
        w_ack = 1'b1;
        w_data = {29'h0, a};
        @(posedge clk);
        #1;
        w_ack = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    vecs = '{4'b1001, 4'b0000, 4'b1100, 4'b1001, 4'b1010, 4'b0110, 4'b1001, 4'b1110,
             4'b0000, 4'b1001, 4'b1001, 4'b0000, 4'b1010, 4'b1001, 4'b0000, 4'b1001};

    reset = 1'b1; enable = 1'b0; ce_pix = 1'b0; hblank = 1'b0; vblank = 1'b0;
    vsync = 1'b0; w_enable = 1'b0;
    repeat (3) tick();
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_addr", {8'h0, mem_addr}, 32'h0);
    check("rst_bg", {16'h0, bg_a, bg_b, bg_g, bg_r}, 32'h0);
    check("rst_underrun", {31'h0, underrun}, 32'h0);
    reset = 1'b0;
    tick();

    // Enabled but no frame start yet: stays idle
    enable = 1'b1;
    repeat (10) tick();
    check("idle_no_req", req_log.size(), 0);

    // Prime: four requests at 0,2,4,6 then none while full
    pulse_vsync();
    wait_reqs(4, 200, "prime_reqs");
    repeat (20) tick();
    for (int i = 0; i < 4; i++) check($sformatf("prime_addr%0d", i), {8'h0, req_log[i]}, 32'(2 * i));
    check("full_no_req", req_log.size(), 4);

    // First word split into two pixels, then refill at address 8
    drive(1'b1, 1'b0, 1'b0, 1'b1, "pix_lo");
    drive(1'b1, 1'b0, 1'b0, 1'b1, "pix_hi");
    wait_reqs(5, 50, "refill_req");
    check("refill_addr", {8'h0, req_log[4]}, 32'h8);
    repeat (10) tick();

    // Table of strobe/blanking combinations
    for (int i = 0; i < 16; i++)
      drive(vecs[i].ce, vecs[i].hb, vecs[i].vb, vecs[i].adv, $sformatf("vec%0d", i));
    check("no_underrun", {31'h0, underrun}, 32'h0);

    // Slow memory with continuous demand: underrun
    ack_lat = 40;
    k = 0;
    ce_pix = 1'b1;
    while (underrun !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    ce_pix = 1'b0;
    check("underrun_set", {31'h0, underrun}, 32'h1);
    check("underrun_bg", {16'h0, bg_a, bg_b, bg_g, bg_r}, 32'h0);
    last_exp = 16'h0;
    n = req_log.size();
    pulse_vsync();
    check("underrun_clr", {31'h0, underrun}, 32'h0);
    ack_lat = 5;
    wait_reqs(n + 4, 300, "reprime_reqs");
    check("reprime_addr", {8'h0, req_log[n]}, 32'h0);
    repeat (15) tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, "reprime_lo");
    drive(1'b1, 1'b0, 1'b0, 1'b1, "reprime_hi");

    // Frame start while the fetch at 0x1A is in flight
    ack_lat = 3;
    k = 0;
    while (req_log[$] != 24'h1A && k < 600) begin
      if (req_log[$] == 24'h18) ack_lat = 30;
      drive((k % 4) == 0, 1'b0, 1'b0, (k % 4) == 0, "run_pix");
      k++;
    end
    check("reach_1a", {8'h0, req_log[$]}, 32'h1A);
    n = req_log.size();
    pulse_vsync();
    ack_lat = 5;
    wait_reqs(n + 1, 200, "drop_restart");
    check("drop_restart_addr", {8'h0, req_log[n]}, 32'h0);
    check("drop_after_ack", 32'(req_cyc[n] > last_ack_cyc), 32'd1);
    wait_reqs(n + 4, 300, "drop_reprime");
    repeat (15) tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, "drop_pix_lo");
    drive(1'b1, 1'b0, 1'b0, 1'b1, "drop_pix_hi");

    // Enable falls mid-line, then re-enable without a frame start
    enable = 1'b0;
    last_exp = 16'h0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, "disable_bg");
    n = req_log.size();
    repeat (30) tick();
    check("disabled_no_req", req_log.size(), n);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, "reenable_bg");
    repeat (20) tick();
    check("reenable_no_req", req_log.size(), n);
    pulse_vsync();
    wait_reqs(n + 1, 200, "reenable_req");
    check("reenable_addr", {8'h0, req_log[n]}, 32'h0);
    wait_reqs(n + 4, 300, "reenable_prime");
    repeat (15) tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, "reenable_pix");

    // Address wrap on the narrow instance: 0,2,4,6 then back to 0
    enable = 1'b0;
    w_enable = 1'b1;
    pulse_vsync();
    k = 0;
    while (w_log.size() < 5 && k < 300) begin
      ce_pix = ((k % 3) == 0);
      tick();
      k++;
    end
    ce_pix = 1'b0;
    check("wrap_reqs", 32'(w_log.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) check($sformatf("wrap_addr%0d", i), {29'h0, w_log[i]}, 32'((2 * i) % 8));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
